// File: rtl/laundry_req_scheduler.sv
// Round-robin scheduler for per-floor laundry pickup requests.
// Captures request edges as pending bits and hands one floor at a time to
// the laundry controller. It then waits for wash_done, or gives up after
// TIMEOUT_CYCLES, before issuing the next floor.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing in service; waiting for any pending bit
// ISSUE     | selected floor on send, start pulses for this one cycle
// WAIT_DONE | floor in service; waiting for wash_done or timeout
// GAP       | dead cycle with send=0000 before returning to IDLE
module laundry_req_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req_laundry,
  input  logic       wash_done,
  output logic       start,
  output logic [3:0] send,
  output logic [3:0] pending,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] served_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  // Last WAIT_DONE cycle index; the counter starts at 0 in the first WAIT_DONE cycle.
  localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  req_prev;
  logic [3:0]  new_req;
  logic [3:0]  clr;
  logic [1:0]  last_served;
  logic [1:0]  sel_floor;
  logic [1:0]  cand;
  logic        sel_valid;
  logic        issue_go;
  logic        done_evt;
  logic [15:0] tmo_cnt;

  assign new_req = req_laundry & ~req_prev;
  assign busy    = (state != IDLE);
  assign clr     = (done_evt || timeout_err) ? send : 4'b0000;

  // Round-robin pick: the first pending floor after last_served, wrapping mod 4.
  always_comb begin
    sel_valid = 1'b0;
    sel_floor = last_served;
    cand      = last_served;
    for (int k = 1; k <= 4; k++) begin
      cand = last_served + 2'(k);
      if (!sel_valid && pending[cand]) begin
        sel_valid = 1'b1;
        sel_floor = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and per-state strobes. A coincident wash_done beats the timeout.
  always_comb begin
    next_state  = state;
    start       = 1'b0;
    timeout_err = 1'b0;
    done_evt    = 1'b0;
    issue_go    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          issue_go   = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        start      = 1'b1;
        next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (wash_done) begin
          done_evt   = 1'b1;
          next_state = GAP;
        end else if (tmo_cnt == TC_LAST) begin
          timeout_err = 1'b1;
          next_state  = GAP;
        end
      end
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture, in-service floor, round-robin pointer, timeout counter and service count.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_prev     <= 4'b0000;
      pending      <= 4'b0000;
      send         <= 4'b0000;
      last_served  <= 2'd3;
      tmo_cnt      <= 16'd0;
      served_count <= 8'd0;
    end else begin
      req_prev <= req_laundry;
      // A fresh edge on the floor being cleared wins, so it is served again.
      pending  <= (pending & ~clr) | new_req;
      if (issue_go) begin
        send        <= 4'b0001 << sel_floor;
        last_served <= sel_floor;
      end else if (done_evt || timeout_err) begin
        send <= 4'b0000;
      end
      if (state == ISSUE)          tmo_cnt <= 16'd0;
      else if (state == WAIT_DONE) tmo_cnt <= tmo_cnt + 16'd1;
      if (done_evt) served_count <= served_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_laundry_req_scheduler.sv
// Directed bench for laundry_req_scheduler with a short timeout (8 cycles).
module tb_laundry_req_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_laundry;
  logic       wash_done;
  logic       start;
  logic [3:0] send;
  logic [3:0] pending;
  logic       busy;
  logic       timeout_err;
  logic [7:0] served_count;

  int checks = 0;
  int errors = 0;

  laundry_req_scheduler #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_laundry  (req_laundry),
    .wash_done    (wash_done),
    .start        (start),
    .send         (send),
    .pending      (pending),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .served_count (served_count)
  );

  always #5 clk = ~clk;

  // One clock: outputs are sampled and inputs changed 1 time unit after the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    req_laundry = 4'b0000;
    wash_done   = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  // From an ISSUE cycle: wait n WAIT_DONE cycles, then pulse wash_done; ends in GAP.
  task automatic serve(input int n);
    step(n);
    wash_done = 1'b1;
    step();
    wash_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_laundry = 4'b0000; wash_done = 1'b0;
    step(2);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", start); end
    checks++; if (send !== 4'b0000) begin errors++; $display("FAIL rst_send got %b exp 0000", send); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_pending got %b exp 0000", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_tmo got %b exp 0", timeout_err); end
    checks++; if (served_count !== 8'd0) begin errors++; $display("FAIL rst_served got %0d exp 0", served_count); end
    reset = 1'b0;
    wash_done = 1'b1;
    step();
    wash_done = 1'b0;
    checks++; if (served_count !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL idle_wash_ignored got served=%0d busy=%b exp 0 0", served_count, busy); end
    req_laundry = 4'b0001;
    step();
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL first_pending got %b exp 0001", pending); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL first_nostart got %b exp 0", start); end
    step();
    checks++; if (start !== 1'b1 || send !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL first_issue got start=%b send=%b busy=%b exp 1 0001 1", start, send, busy); end
    step();
    checks++; if (start !== 1'b0 || send !== 4'b0001) begin errors++; $display("FAIL first_wait got start=%b send=%b exp 0 0001", start, send); end
    wash_done = 1'b1; req_laundry = 4'b0000;
    step();
    wash_done = 1'b0;
    checks++; if (served_count !== 8'd1 || pending !== 4'b0000 || send !== 4'b0000) begin errors++; $display("FAIL first_done got served=%0d pend=%b send=%b exp 1 0000 0000", served_count, pending, send); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req_laundry = 4'b1001;
    step();
    checks++; if (pending !== 4'b1001) begin errors++; $display("FAIL rr_pending got %b exp 1001", pending); end
    step();
    checks++; if (start !== 1'b1 || send !== 4'b0001) begin errors++; $display("FAIL rr_issue1 got start=%b send=%b exp 1 0001", start, send); end
    serve(4);
    checks++; if (send !== 4'b0000 || pending !== 4'b1000 || served_count !== 8'd1) begin errors++; $display("FAIL rr_done1 got send=%b pend=%b served=%0d exp 0000 1000 1", send, pending, served_count); end
    step();
    checks++; if (send !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rr_dead got send=%b busy=%b exp 0000 0", send, busy); end
    step();
    checks++; if (start !== 1'b1 || send !== 4'b1000) begin errors++; $display("FAIL rr_issue2 got start=%b send=%b exp 1 1000", start, send); end
    serve(4);
    checks++; if (served_count !== 8'd2 || pending !== 4'b0000) begin errors++; $display("FAIL rr_done2 got served=%0d pend=%b exp 2 0000", served_count, pending); end
  endtask

  task automatic test_all_floors();
    apply_reset();
    req_laundry = 4'b0010;
    step(2);
    checks++; if (send !== 4'b0010) begin errors++; $display("FAIL all_issue_f1 got %b exp 0010", send); end
    step();
    req_laundry = 4'b1111;
    step();
    checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL all_pending got %b exp 1111", pending); end
    wash_done = 1'b1;
    step();
    wash_done = 1'b0;
    checks++; if (pending !== 4'b1101) begin errors++; $display("FAIL all_clr_f1 got %b exp 1101", pending); end
    step(2);
    checks++; if (send !== 4'b0100) begin errors++; $display("FAIL all_order1 got %b exp 0100", send); end
    serve(2);
    step(2);
    checks++; if (send !== 4'b1000) begin errors++; $display("FAIL all_order2 got %b exp 1000", send); end
    serve(2);
    step(2);
    checks++; if (send !== 4'b0001) begin errors++; $display("FAIL all_order3 got %b exp 0001", send); end
    serve(2);
    checks++; if (pending !== 4'b0000 || served_count !== 8'd4) begin errors++; $display("FAIL all_final got pend=%b served=%0d exp 0000 4", pending, served_count); end
    step(2);
    checks++; if (busy !== 1'b0 || send !== 4'b0000) begin errors++; $display("FAIL all_no_reserve got busy=%b send=%b exp 0 0000", busy, send); end
  endtask

  task automatic test_timeout();
    apply_reset();
    req_laundry = 4'b0100;
    step(2);
    checks++; if (send !== 4'b0100 || start !== 1'b1) begin errors++; $display("FAIL tmo_issue got send=%b start=%b exp 0100 1", send, start); end
    step(7);
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early got tmo=%b busy=%b exp 0 1", timeout_err, busy); end
    step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_pulse got %b exp 1", timeout_err); end
    step();
    checks++; if (timeout_err !== 1'b0 || pending !== 4'b0000 || served_count !== 8'd0 || send !== 4'b0000) begin errors++; $display("FAIL tmo_after got tmo=%b pend=%b served=%0d send=%b exp 0 0000 0 0000", timeout_err, pending, served_count, send); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_coincident();
    apply_reset();
    req_laundry = 4'b1000;
    step(2);
    checks++; if (send !== 4'b1000) begin errors++; $display("FAIL co_issue got %b exp 1000", send); end
    step();
    req_laundry = 4'b0000;
    step();
    req_laundry = 4'b1000; wash_done = 1'b1;
    step();
    wash_done = 1'b0;
    checks++; if (served_count !== 8'd1 || pending !== 4'b1000 || timeout_err !== 1'b0) begin errors++; $display("FAIL co_done got served=%0d pend=%b tmo=%b exp 1 1000 0", served_count, pending, timeout_err); end
    step(2);
    checks++; if (start !== 1'b1 || send !== 4'b1000) begin errors++; $display("FAIL co_reissue got start=%b send=%b exp 1 1000", start, send); end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    req_laundry = 4'b0110;
    step(2);
    checks++; if (send !== 4'b0010) begin errors++; $display("FAIL mid_issue got %b exp 0010", send); end
    step();
    checks++; if (pending !== 4'b0110 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got pend=%b busy=%b exp 0110 1", pending, busy); end
    reset = 1'b1; req_laundry = 4'b0100;
    step();
    checks++; if (send !== 4'b0000 || pending !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL mid_rst got send=%b pend=%b busy=%b tmo=%b exp 0000 0000 0 0", send, pending, busy, timeout_err); end
    reset = 1'b0;
    step();
    checks++; if (pending !== 4'b0100 || busy !== 1'b0) begin errors++; $display("FAIL mid_recapture got pend=%b busy=%b exp 0100 0", pending, busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_laundry = 4'b0000; wash_done = 1'b0;
    test_reset();
    test_round_robin();
    test_all_floors();
    test_timeout();
    test_coincident();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
